// File: rtl/inst_fetch_bridge_if.sv
// Instruction-memory request/response bus between inst_fetch_bridge (master) and memory (slave).
// FETCH_ERR_EN adds the mem_resp_err response flag.
interface inst_fetch_bridge_if #(parameter int ADDR_W = 64);
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [63:0]       mem_resp_data;
`ifdef FETCH_ERR_EN
  logic              mem_resp_err;
`endif

  modport master (
`ifdef FETCH_ERR_EN
    input  mem_resp_err,
`endif
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
`ifdef FETCH_ERR_EN
    output mem_resp_err,
`endif
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/inst_fetch_bridge.sv
// Fetch bridge: turns an if_stage fetch into a valid/ready memory request, selects the 32-bit word
// and stalls the pipe until ID accepts it. Optional FETCH_ERR_EN adds misalign/bus-error reporting.
module inst_fetch_bridge #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] PC_START = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  input  logic              flush_i,
  input  logic              id_ready_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  output logic              fetch_stall_o,
`ifdef FETCH_ERR_EN
  output logic              inst_err_o,
`endif
  inst_fetch_bridge_if.master mem
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  // The boot address lives in if_stage; here it only has to be a legal fetch target.
  if (PC_START[1:0] != 2'b00) begin : g_pc_start_chk
    $error("PC_START must be word aligned");
  end

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              start;
`ifdef FETCH_ERR_EN
  logic              err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    start     = 1'b0;
`ifdef FETCH_ERR_EN
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pc_valid_i && !flush_i) start = 1'b1;
      end
      S_REQ: begin
        // A raised request stays up until accepted; a flush only marks its response for disposal.
        if (flush_i) drop_d = 1'b1;
        if (mem.mem_req_ready) state_d = (drop_q || flush_i) ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (mem.mem_resp_valid) begin
          if (flush_i) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_HOLD;
            inst_d    = pc_q[2] ? mem.mem_resp_data[63:32] : mem.mem_resp_data[31:0];
            inst_pc_d = pc_q;
`ifdef FETCH_ERR_EN
            err_d     = mem.mem_resp_err;
            if (mem.mem_resp_err) inst_d = NOP;
`endif
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem.mem_resp_valid) state_d = S_IDLE;
      end
      S_HOLD: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (id_ready_i) begin
          if (pc_valid_i) start = 1'b1;
          else            state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      pc_d    = pc_i;
      drop_d  = 1'b0;
      state_d = S_REQ;
`ifdef FETCH_ERR_EN
      // Misaligned fetches never reach memory; they retire as a flagged nop.
      if (pc_i[1:0] != 2'b00) begin
        state_d   = S_HOLD;
        inst_d    = NOP;
        inst_pc_d = pc_i;
        err_d     = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
`ifdef FETCH_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
`ifdef FETCH_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  assign mem.mem_req_valid = (state_q == S_REQ);
  assign mem.mem_req_addr  = {pc_q[ADDR_W-1:3], 3'b000};
  assign inst_o            = inst_q;
  assign inst_pc_o         = inst_pc_q;
  assign inst_valid_o      = (state_q == S_HOLD);
  assign fetch_stall_o     = rst && pc_valid_i && !flush_i && !((state_q == S_HOLD) && id_ready_i);
`ifdef FETCH_ERR_EN
  assign inst_err_o        = err_q;
`endif

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Bench for inst_fetch_bridge: directed scenarios plus random traffic against a transaction-level model.
module tb_inst_fetch_bridge;
  localparam int          AW  = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc_i;
  logic          pc_valid_i, flush_i, id_ready_i;
  logic [31:0]   inst_o;
  logic [AW-1:0] inst_pc_o;
  logic          inst_valid_o, fetch_stall_o;
`ifdef FETCH_ERR_EN
  logic          inst_err_o;
`endif

  always #5 clk = ~clk;

  inst_fetch_bridge_if #(.ADDR_W(AW)) mem_if ();

  inst_fetch_bridge #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .flush_i(flush_i),
    .id_ready_i(id_ready_i), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_valid_o(inst_valid_o), .fetch_stall_o(fetch_stall_o),
`ifdef FETCH_ERR_EN
    .inst_err_o(inst_err_o),
`endif
    .mem(mem_if.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction view: a request waiting for ready, an accepted request awaiting its beat
  // (possibly doomed), or a fetched instruction waiting for ID. None of them = idle.
  bit          m_req, m_out, m_kill, m_have, m_drop, m_err;
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_inst;

  // Memory side: one outstanding response, delivered lat cycles after acceptance.
  int          mem_cnt;
  int          lat;
  logic        rdy_want;
  logic [63:0] next_data;
  logic        next_err;

  task automatic start_fetch(logic [63:0] p);
    m_pc   = p;
    m_drop = 0;
`ifdef FETCH_ERR_EN
    if (p[1:0] != 2'b00) begin
      m_have = 1; m_inst = NOP; m_ipc = p; m_err = 1;
    end else m_req = 1;
`else
    m_req = 1;
`endif
  endtask

  task automatic model_edge();
    bit acc;
    acc = m_req && mem_if.mem_req_ready;
    if (!rst) begin
      m_req = 0; m_out = 0; m_kill = 0; m_have = 0; m_drop = 0; m_err = 0;
      m_pc = '0; m_ipc = '0; m_inst = '0;
    end else if (m_req) begin
      if (flush_i) m_drop = 1;
      if (mem_if.mem_req_ready) begin
        m_req = 0; m_out = 1; m_kill = m_drop;
      end
    end else if (m_out) begin
      if (mem_if.mem_resp_valid) begin
        m_out = 0;
        if (!m_kill && !flush_i) begin
          m_have = 1;
          m_ipc  = m_pc;
          m_inst = m_pc[2] ? mem_if.mem_resp_data[63:32] : mem_if.mem_resp_data[31:0];
          m_err  = 0;
`ifdef FETCH_ERR_EN
          if (mem_if.mem_resp_err) begin m_inst = NOP; m_err = 1; end
`endif
        end
      end else if (flush_i) m_kill = 1;
    end else if (m_have) begin
      if (flush_i) m_have = 0;
      else if (id_ready_i) begin
        m_have = 0;
        if (pc_valid_i) start_fetch(pc_i);
      end
    end else if (pc_valid_i && !flush_i) begin
      start_fetch(pc_i);
    end
    if (mem_cnt > 0) mem_cnt--;
    if (acc) mem_cnt = lat;
  endtask

  // Called at a falling edge with the fetch-side inputs already set; returns at the next falling edge.
  task automatic tick();
    mem_if.mem_req_ready  = rdy_want && (mem_cnt == 0);
    mem_if.mem_resp_valid = (mem_cnt == 1);
    mem_if.mem_resp_data  = next_data;
`ifdef FETCH_ERR_EN
    mem_if.mem_resp_err   = (mem_cnt == 1) && next_err;
`endif
    #1;
    chk("req_valid", 64'(mem_if.mem_req_valid), 64'(m_req));
    chk("req_addr", mem_if.mem_req_addr, {m_pc[63:3], 3'b000});
    chk("inst_valid", 64'(inst_valid_o), 64'(m_have));
    chk("stall", 64'(fetch_stall_o), 64'(rst && pc_valid_i && !flush_i && !(m_have && id_ready_i)));
    if (m_have) begin
      chk("inst", 64'(inst_o), 64'(m_inst));
      chk("inst_pc", inst_pc_o, m_ipc);
`ifdef FETCH_ERR_EN
      chk("inst_err", 64'(inst_err_o), 64'(m_err));
`endif
    end
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b0; pc_i = '0; pc_valid_i = 1'b0; flush_i = 1'b0; id_ready_i = 1'b0;
    rdy_want = 1'b0; lat = 1; next_data = '0; next_err = 1'b0; mem_cnt = 0;
    mem_if.mem_req_ready = 1'b0; mem_if.mem_resp_valid = 1'b0; mem_if.mem_resp_data = '0;
`ifdef FETCH_ERR_EN
    mem_if.mem_resp_err = 1'b0;
`endif
    m_req = 0; m_out = 0; m_kill = 0; m_have = 0; m_drop = 0; m_err = 0;
    m_pc = '0; m_ipc = '0; m_inst = '0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);

    // Reset held, fetch requested: stall must stay low and everything reads zero.
    pc_valid_i = 1'b1; pc_i = 64'h8000_0000;
    tick();
    chk("rst_inst", 64'(inst_o), 64'h0);
    chk("rst_inst_pc", inst_pc_o, 64'h0);
    chk("rst_inst_valid", 64'(inst_valid_o), 64'h0);
`ifdef FETCH_ERR_EN
    chk("rst_inst_err", 64'(inst_err_o), 64'h0);
`endif

    // Single fetch, upper word.
    rst = 1'b1; pc_i = 64'h8000_0004; rdy_want = 1'b1; id_ready_i = 1'b1;
    next_data = 64'h00A0_0513_0010_0093; lat = 1;
    tick();
    chk("t1_req_valid", 64'(mem_if.mem_req_valid), 64'h1);
    chk("t1_req_addr", mem_if.mem_req_addr, 64'h8000_0000);
    tick(); tick();
    chk("t1_inst_valid", 64'(inst_valid_o), 64'h1);
    chk("t1_inst", 64'(inst_o), 64'h00A0_0513);
    chk("t1_inst_pc", inst_pc_o, 64'h8000_0004);
    pc_valid_i = 1'b0;
    tick();

    // Backpressure on both sides.
    pc_valid_i = 1'b1; pc_i = 64'h8000_0010; rdy_want = 1'b0; id_ready_i = 1'b0;
    next_data = 64'h1111_2222_3333_4444;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_req_hold", 64'(mem_if.mem_req_valid), 64'h1);
      chk("t2_addr_hold", mem_if.mem_req_addr, 64'h8000_0010);
      tick();
    end
    rdy_want = 1'b1;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk("t2_inst_hold", 64'(inst_o), 64'h3333_4444);
      chk("t2_stall_hold", 64'(fetch_stall_o), 64'h1);
      tick();
    end
    id_ready_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    repeat (4) tick();

    // Flush while waiting for the beat.
    pc_valid_i = 1'b1; pc_i = 64'h8000_0040; lat = 2;
    tick(); tick();
    flush_i = 1'b1; pc_i = 64'h8000_0100;
    tick();
    flush_i = 1'b0;
    tick(); tick();
    chk("t3_inst_valid", 64'(inst_valid_o), 64'h0);
    chk("t3_addr", mem_if.mem_req_addr, 64'h8000_0100);
    pc_valid_i = 1'b0; lat = 1;
    repeat (4) tick();

    // Flush in REQ before ready, then flush coincident with the response.
    pc_valid_i = 1'b1; pc_i = 64'h8000_0200; rdy_want = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; pc_valid_i = 1'b0;
    tick();
    chk("t4_req_kept", 64'(mem_if.mem_req_valid), 64'h1);
    rdy_want = 1'b1;
    tick(); tick(); tick();
    chk("t4_drain_valid", 64'(inst_valid_o), 64'h0);
    pc_valid_i = 1'b1; pc_i = 64'h8000_0300;
    tick(); tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; pc_valid_i = 1'b0;
    tick();
    chk("t4_coinc_valid", 64'(inst_valid_o), 64'h0);

    // Back-to-back sequential fetches.
    pc_valid_i = 1'b1; id_ready_i = 1'b1; rdy_want = 1'b1; lat = 1;
    for (int k = 0; k < 4; k++) begin
      logic [63:0] pc;
      pc = 64'h8000_0000 + 64'(4 * k);
      pc_i = pc;
      next_data = {32'hB000_0000 | 32'(k), 32'hA000_0000 | 32'(k)};
      for (int j = 0; j < 3; j++) begin
        tick();
        chk("t5_cadence", 64'(inst_valid_o), 64'(j == 2));
      end
      chk("t5_inst", 64'(inst_o), 64'(pc[2] ? (32'hB000_0000 | 32'(k)) : (32'hA000_0000 | 32'(k))));
      chk("t5_inst_pc", inst_pc_o, pc);
    end
    pc_valid_i = 1'b0;
    tick();

    // Reset while waiting; the late beat must be ignored.
    pc_valid_i = 1'b1; pc_i = 64'h8000_0400; lat = 2;
    tick(); tick();
    rst = 1'b0; pc_valid_i = 1'b0;
    tick();
    rst = 1'b1;
    chk("t6_req_valid", 64'(mem_if.mem_req_valid), 64'h0);
    chk("t6_addr", mem_if.mem_req_addr, 64'h0);
    chk("t6_inst", 64'(inst_o), 64'h0);
    chk("t6_inst_pc", inst_pc_o, 64'h0);
    tick(); tick();
    chk("t6_stale", 64'(inst_valid_o), 64'h0);

`ifdef FETCH_ERR_EN
    pc_valid_i = 1'b1; pc_i = 64'h8000_0002; id_ready_i = 1'b0;
    tick();
    chk("err_no_req", 64'(mem_if.mem_req_valid), 64'h0);
    chk("err_valid", 64'(inst_valid_o), 64'h1);
    chk("err_nop", 64'(inst_o), 64'(NOP));
    chk("err_flag", 64'(inst_err_o), 64'h1);
    pc_valid_i = 1'b0; id_ready_i = 1'b1;
    tick();
`endif

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      rst        = ($urandom_range(0, 99) != 0);
      pc_valid_i = ($urandom_range(0, 9) < 7);
      flush_i    = ($urandom_range(0, 9) == 0);
      id_ready_i = ($urandom_range(0, 9) < 6);
      rdy_want   = ($urandom_range(0, 9) < 6);
      lat        = int'($urandom_range(1, 3));
      next_data  = {$urandom, $urandom};
      next_err   = ($urandom_range(0, 3) == 0);
      pc_i       = 64'h8000_0000 + 64'($urandom_range(0, 1023) * 4)
                   + (($urandom_range(0, 7) == 0) ? 64'($urandom_range(1, 3)) : 64'h0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_fetch_bridge.md
Name: inst_fetch_bridge

Overview:
- Sits between if_stage/if_id and instruction memory.
- Replaces the single-cycle combinational instruction read with a valid/ready request port and a variable-latency response port.
- Selects the 32-bit instruction from the 64-bit memory beat.
- Drives a stall request to the hazard unit until the instruction is accepted.
- On a branch/jump redirect (transfer), discards any in-flight response.

Parameters:
- PC_START, 64'h80000000, reset/boot address; mem_req_addr_o is the absolute byte address.
- ADDR_W, 64, width of PC and memory address.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (0 = reset)
- pc_i  in  ADDR_W  fetch address from if_stage
- pc_valid_i  in  1  fetch enable from if_stage (inst_ena)
- flush_i  in  1  redirect from pc_mux (transfer); kills the current fetch
- id_ready_i  in  1  if_id can accept an instruction this cycle (not stalled)
- inst_o  out  32  fetched instruction
- inst_pc_o  out  ADDR_W  PC of inst_o
- inst_valid_o  out  1  inst_o/inst_pc_o valid
- fetch_stall_o  out  1  to hazard_unit; holds PC and if_id
- mem_req_valid_o  out  1  memory request valid
- mem_req_addr_o  out  ADDR_W  {pc[63:3],3'b000}
- mem_req_ready_i  in  1  memory accepts the request
- mem_resp_valid_i  in  1  response beat valid
- mem_resp_data_i  in  64  response beat

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE, pc_q=0, and all outputs 0.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE:
  - pc_valid_i=1 and flush_i=0 → capture pc_q=pc_i, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - mem_req_valid_o=1 (registered), mem_req_addr_o={pc_q[63:3],3'b0}.
  - Valid and address stay stable until mem_req_ready_i=1.
  - On ready, go to WAIT; if flush_i was seen at any point in REQ (sticky drop flag), go to DRAIN instead.
  - A request is never withdrawn once raised.
- WAIT: on mem_resp_valid_i:
  - flush_i=0 → latch inst_o = pc_q[2] ? data[63:32] : data[31:0], inst_pc_o=pc_q, go to HOLD.
  - flush_i=1 (same cycle) → discard, go to IDLE.
  - flush_i=1 with no response → go to DRAIN.
- DRAIN: on mem_resp_valid_i, discard the data and go to IDLE. inst_valid_o=0 throughout.
- HOLD: inst_valid_o=1; inst_o/inst_pc_o stay stable while id_ready_i=0.
  - id_ready_i=1 and flush_i=0: handshake completes. If pc_valid_i=1, capture pc_q=pc_i and go directly to REQ; else go to IDLE.
  - flush_i=1: inst_valid_o drops next cycle; go to IDLE.
- fetch_stall_o (combinational) = pc_valid_i & ~flush_i & ~(state==HOLD & id_ready_i). Forced 0 during reset.
- mem_resp_valid_i in IDLE/REQ/HOLD is ignored; the memory guarantees at most one outstanding response.
- Latency with memory ready in the same cycle and a 1-cycle response:
  - pc_valid_i edge → REQ +1 → WAIT +2 → HOLD/inst_valid_o +3.
  - Back-to-back throughput is 1 instruction per 3 cycles.
- Reset mid-operation: state returns to IDLE immediately. A response arriving later lands in IDLE and is ignored.

Optional Feature:
- Macro: FETCH_ERR_EN.
- When defined:
  - Adds port mem_resp_err_i (in 1) and inst_err_o (out 1, reset 0).
  - pc_i[1:0]!=0 in IDLE/HOLD capture → no memory request; go straight to HOLD with inst_o=32'h00000013 (nop), inst_err_o=1.
  - A response with mem_resp_err_i=1 in WAIT → HOLD with nop and inst_err_o=1.
  - inst_err_o is valid only while inst_valid_o=1.
- When undefined: the ports are absent, pc_i[1:0] is ignored, and response data is used unconditionally.

Test Plan:
1. Single fetch: rst released, pc_i=0x80000004, pc_valid_i=1, ready=1, response 1 cycle after acceptance with data 0x00A0051300100093, id_ready_i=1 → inst_valid_o=1 on cycle 3, inst_o=0x00A00513, inst_pc_o=0x80000004, mem_req_addr_o=0x80000000.
2. Backpressure: mem_req_ready_i low 4 cycles then high; id_ready_i low 3 cycles in HOLD → mem_req_valid_o/addr stable for 5 cycles; inst_o and inst_valid_o stable until id_ready_i=1; fetch_stall_o=1 throughout, 0 in the accepting cycle.
3. Flush in WAIT: flush_i pulsed 1 cycle before the response, pc_i=0x80000100 → response discarded (inst_valid_o stays 0); next request addr 0x80000100.
4. Flush coincident with response, and flush in REQ before ready → no inst_valid_o for the old PC; in the REQ case mem_req_valid_o is held until ready, then DRAIN consumes exactly one response.
5. Back-to-back: 4 sequential PCs 0x80000000..0x8000000C with always-ready memory → inst_valid_o every 3rd cycle, correct low/high words alternating, inst_pc_o matching.
6. Reset mid-WAIT: rst=0 for 1 cycle, then a stale response arrives → all outputs 0, state IDLE, stale response ignored; FETCH_ERR_EN build: pc_i=0x80000002 → no mem request, inst_o=0x00000013, inst_err_o=1.
